// File: rtl/smallcpu_pkg.sv
// Shared constants and the loader state encoding for the small cpu boot path.
package smallcpu_pkg;

   localparam int unsigned WORD_WIDTH     = 16;
   localparam int unsigned MEM_DEPTH      = 1024;
   localparam int unsigned LOAD_BASE_ADDR = 1;

   typedef enum logic [3:0] {
      StIdle,
      StLenH,
      StLenL,
      StDatH,
      StDatL,
      StWr,
      StChk,
      StDone,
      StErr
   } loader_state_e;

   // Largest program that fits between the load base and the top of memory.
   function automatic logic [15:0] max_len(input int unsigned depth, input int unsigned base);
      return 16'(depth - base);
   endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: packs a length-prefixed byte stream into instruction words and releases the cpu.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import smallcpu_pkg::*;
#(
   parameter int unsigned N         = WORD_WIDTH,
   parameter int unsigned M         = MEM_DEPTH,
   parameter int unsigned LOAD_BASE = LOAD_BASE_ADDR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         mem_we,
   output logic         done,
   output logic         error,
   output logic         cpu_run
);

   localparam logic [15:0] MaxLen = max_len(M, LOAD_BASE);

   loader_state_e state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   idx_q, idx_d;
   logic [7:0]    hi_q, hi_d;
   logic [N-1:0]  addr_q, addr_d;
   logic [N-1:0]  wdata_q, wdata_d;
   logic          accept;
   logic [15:0]   len_full;
   logic [15:0]   idx_inc;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   always_comb begin
      unique case (state_q)
         StLenH, StLenL, StDatH, StDatL, StChk: in_ready = 1'b1;
         default:                               in_ready = 1'b0;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign len_full  = {len_q[15:8], in_data};
   assign idx_inc   = idx_q + 16'd1;

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state_q == StWr);
   assign done      = (state_q == StDone);
   assign error     = (state_q == StErr);
   assign cpu_run   = done;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         StIdle: state_d = StLenH;

         StLenH: begin
            if (accept) begin
               len_d[15:8] = in_data;
               state_d     = StLenL;
            end
         end

         StLenL: begin
            if (accept) begin
               len_d[7:0] = in_data;
               idx_d      = '0;
               if (len_full == 16'd0) begin
                  state_d = StDone;
               end else if (len_full > MaxLen) begin
                  state_d = StErr;
               end else begin
                  state_d = StDatH;
               end
            end
         end

         StDatH: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = StDatL;
            end
         end

         StDatL: begin
            if (accept) begin
               wdata_d = N'({hi_q, in_data});
               addr_d  = N'(LOAD_BASE) + N'(idx_q);
               state_d = StWr;
            end
         end

         StWr: begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StDatH;
            end
         end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StChk: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? StDone : StErr;
            end
         end
`endif

         StDone: state_d = StDone;
         StErr:  state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         hi_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // Running XOR of every accepted byte ahead of the checksum itself.
   always_comb begin
      csum_d = csum_q;
      if (accept && state_q != StChk) begin
         csum_d = csum_q ^ in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed cases plus randomized streams vs a stream-level model.
module tb_program_loader;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        done;
   logic        error;
   logic        cpu_run;

   int n_tests = 0;
   int n_fail  = 0;

   word_q_t got_q;
   word_q_t exp_q;
   int      we_ready_viol;
   bit      exp_done;
   bit      exp_err;
   int      exp_acc;

   program_loader dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .done     (done),
      .error    (error),
      .cpu_run  (cpu_run)
   );

   always #5 clk = ~clk;

   // Memory-side monitor: every write strobe observed mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         got_q.push_back({mem_addr, mem_wdata});
         if (in_ready !== 1'b0) we_ready_viol++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: what the loader should write and how it should finish, from the stream alone.
   task automatic model(input byte_q_t s);
      int unsigned len;
      logic [7:0]  x;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      len      = {s[0], s[1]};
      x        = s[0] ^ s[1];
      if (len == 0) begin
         exp_done = 1;
         exp_acc  = 2;
      end else if (len > 1023) begin
         exp_err = 1;
         exp_acc = 2;
      end else begin
         for (int k = 0; k < int'(len); k++) begin
            exp_q.push_back({16'(1 + k), s[2 + 2 * k], s[3 + 2 * k]});
            x = x ^ s[2 + 2 * k] ^ s[3 + 2 * k];
         end
         exp_acc = 2 + 2 * int'(len);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         exp_acc = exp_acc + 1;
         if (s[2 + 2 * len] == x) exp_done = 1;
         else                     exp_err  = 1;
`else
         exp_done = 1;
`endif
      end
   endtask

   function automatic byte_q_t with_csum(input byte_q_t s, input bit corrupt);
      byte_q_t    r = s;
      logic [7:0] x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      r.push_back(corrupt ? x ^ 8'h01 : x);
      return r;
   endfunction

   task automatic do_reset(input bit check_vals);
      in_valid = 1'b0;
      in_data  = 8'h00;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (check_vals) begin
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_mem_we", 32'(mem_we), 0);
         check("rst_mem_addr", 32'(mem_addr), 0);
         check("rst_mem_wdata", 32'(mem_wdata), 0);
         check("rst_flags", {29'd0, done, error, cpu_run}, 0);
      end
      rst = 1'b0;
   endtask

   // Feed n bytes; returns right after the posedge that took the last one.
   task automatic send(input byte_q_t s, input int n, input bit rand_valid);
      int  i   = 0;
      int  cyc = 0;
      bit  acc;
      while (i < n && cyc < 2000) begin
         @(negedge clk);
         in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? s[i] : 8'($urandom);
         acc      = in_valid && in_ready;
         @(posedge clk);
         if (acc) i++;
         cyc++;
      end
      #1;
      in_valid = 1'b0;
      if (i != n) check("send_timeout", 32'(i), 32'(n));
   endtask

   task automatic run_stream(input string tag, input byte_q_t s, input bit rand_valid,
                             input int exp_lat);
      int lat = 99;
      model(s);
      got_q.delete();
      we_ready_viol = 0;
      send(s, exp_acc, rand_valid);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done || error) begin
            lat = k;
            break;
         end
      end
      if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      // Offer extra bytes after completion; none may be consumed.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (3) @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      in_valid = 1'b0;
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_done));
      check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < got_q.size()) check({tag, "_write"}, got_q[i], exp_q[i]);
      end
      check({tag, "_we_ready"}, 32'(we_ready_viol), 0);
   endtask

   initial begin
      byte_q_t s;
      byte_q_t t1;
      int      len;
      int      lat1;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Test 1: three words, continuous valid.
      do_reset(1'b1);
      t1 = '{8'h00, 8'h03, 8'h80, 8'h05, 8'h0A, 8'h00, 8'h9F, 8'hFF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      t1   = with_csum(t1, 1'b0);
      lat1 = 1;
`else
      lat1 = 2;
`endif
      run_stream("t1", t1, 1'b0, lat1);

      // Test 2: empty program.
      do_reset(1'b0);
      run_stream("t2", '{8'h00, 8'h00}, 1'b0, 1);

      // Test 3: same as test 1 with random valid gaps.
      do_reset(1'b0);
      run_stream("t3", t1, 1'b1, 0);

      // Test 4: oversize length.
      do_reset(1'b0);
      run_stream("t4", '{8'h04, 8'h00}, 1'b0, 1);

      // Test 5: reset mid-load, then a fresh one-word load.
      do_reset(1'b0);
      got_q.delete();
      send('{8'h00, 8'h03, 8'h80, 8'h05, 8'h0A, 8'h00}, 6, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_pre_nwrites", 32'(got_q.size()), 2);
      if (got_q.size() == 2) check("t5_pre_write2", got_q[1], 32'h0002_0A00);
      check("t5_rst_done", 32'(done), 0);
      s = '{8'h00, 8'h01, 8'h12, 8'h34};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      s.push_back(8'h27);
`endif
      run_stream("t5", s, 1'b0, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Test 6: checksum good and bad.
      do_reset(1'b0);
      run_stream("t6_good", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27}, 1'b0, 1);
      do_reset(1'b0);
      run_stream("t6_bad", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26}, 1'b0, 1);
`endif

      // Randomized streams, with the occasional oversize length.
      for (int it = 0; it < 12; it++) begin
         s.delete();
         len = (it % 5 == 4) ? int'($urandom_range(1024, 65535)) : int'($urandom_range(1, 6));
         s.push_back(8'(len >> 8));
         s.push_back(8'(len));
         if (len <= 1023) begin
            for (int k = 0; k < 2 * len; k++) s.push_back(8'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            s = with_csum(s, 1'($urandom_range(0, 1)));
`endif
         end
         do_reset(1'b0);
         run_stream("rnd", s, 1'b1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the cpu's instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and packs byte pairs into N-bit instruction words.
- Writes each word into the instruction memory through its address/in/write_en port, starting at address LOAD_BASE.
- Asserts cpu_run when loading completes. Until then, cpu_run holds the cpu in reset.

Parameters:
- N, 16, instruction word width in bits; must be 16 (two bytes per word).
- M, 1024, instruction memory depth in words.
- LOAD_BASE, 1, first address written; equals the cpu's initial programCounter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  N  instruction memory write address.
- mem_wdata  output  N  instruction word to write.
- mem_we  output  1  one-cycle write strobe.
- done  output  1  load finished successfully; sticky.
- error  output  1  load aborted; sticky.
- cpu_run  output  1  releases the cpu; equals done.

Behaviour:
- Byte transfer occurs only when in_valid && in_ready at a posedge. in_data is ignored otherwise.
- Stream format: LEN_HI, LEN_LO, then LEN words, each sent high byte first.
- Reset: state IDLE, in_ready=0, mem_addr=0, mem_wdata=0, mem_we=0, done=0, error=0, cpu_run=0. The internal count and index clear. Memory contents are not touched.
- A reset asserted mid-load aborts the load at the next posedge. The next load restarts from the header.
- State IDLE: one cycle after rst deasserts, go to LEN_H.
- States LEN_H and LEN_L:
  - in_ready=1.
  - Capture the length as a 16-bit value, high byte first.
  - After LEN_L:
    - LEN==0 -> DONE, with no writes.
    - LEN>M-LOAD_BASE -> ERR.
    - Otherwise -> DAT_H.
- State DAT_H: in_ready=1; latch the high byte.
- State DAT_L: in_ready=1. On accept, go to WR and register:
  - mem_wdata = {hi, lo}.
  - mem_addr = LOAD_BASE + index.
  - mem_we = 1.
- State WR:
  - Exactly one cycle with mem_we=1 and in_ready=0.
  - index increments.
  - If index+1==LEN, go to DONE (or CHK when the optional feature is compiled in); else go to DAT_H.
  - mem_addr and mem_wdata hold their last values afterwards. mem_we returns to 0.
- Latency: a word is written in the cycle immediately after its low byte is accepted. Maximum throughput is 1 word per 3 cycles.
- in_valid gaps stall the FSM in its current state with no side effects.
- DONE: done=1, cpu_run=1, in_ready=0. Further bytes are never accepted. Stays until rst.
- ERR: error=1, cpu_run=0, in_ready=0. Stays until rst.
- Address arithmetic is N-bit. Wrap-around cannot occur because the length check is applied first.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers all accepted bytes, including the length bytes.
  - After the last WR, state CHK accepts one checksum byte.
  - If the checksum byte equals the running XOR -> DONE; otherwise -> ERR.
  - Words already written stay in memory, but cpu_run never asserts on a mismatch.
- Not defined: no CHK state and no XOR register. WR goes straight to DONE. error asserts only for oversize LEN.

Decomposition:
- Shared package smallcpu_pkg:
  - word width N=16 and memory depth M=1024 constants;
  - LOAD_BASE constant;
  - the loader state enum (IDLE, LEN_H, LEN_L, DAT_H, DAT_L, WR, CHK, DONE, ERR).
- A single FSM module is natural; no sub-module is required.
- The cpu top instantiates program_loader and connects:
  - mem_addr/mem_wdata/mem_we to instMem;
  - cpu_run to the cpu's run/reset gating.

Test Plan:
1. Stream 00 03 | 80 05 | 0A 00 | 9F FF with in_valid always high. Required response:
   - mem_we pulses at addresses 1, 2, 3 with data 0x8005, 0x0A00, 0x9FFF;
   - done=cpu_run=1 two cycles after the final byte;
   - in_ready=0 thereafter.
2. Stream 00 00 -> no mem_we pulse; done=1 the cycle after LEN_LO is accepted.
3. Same stream as test 1 with in_valid toggling randomly -> identical writes. Verify bytes are never taken while in_ready=0 (during WR).
4. Stream 04 00 (LEN=1024 > 1023) -> error=1, no writes, cpu_run stays 0, in_ready=0.
5. Assert rst for one cycle after the second data word is accepted, then send 00 01 12 34 -> a single write at address 1 with data 0x1234; done=1.
6. Checksum (macro defined only):
   - Stream 00 01 12 34 27 -> done=1.
   - The same stream with checksum 26 -> error=1, cpu_run=0; the write to address 1 still occurred.
